uart_tx_cfg: RTL
================

Name: uart_tx_cfg

Overview:
Parametrised UART transmitter and successor to the fixed-format TX block. It supports configurable data width, parity mode (none/even/odd) and 1 or 2 stop bits. The baud divisor is set at run time and sampled per frame. A one-word holding register with a valid/ready handshake allows back-to-back frames with no idle gap. It sits between a byte-stream producer (FIFO or CPU register) and the serial pin.

Parameters:
p_DATA_BITS, 8, data bits per frame; legal 5..9; sent LSB first.
p_PARITY, 0, 0 = none, 1 = even, 2 = odd.
p_STOP_BITS, 1, stop bits per frame; legal 1 or 2.
p_DIV_W, 16, width of the baud divisor input.

Ports:
i_clk  in  1  system clock; all logic on the rising edge.
i_rst_n  in  1  asynchronous active-low reset.
i_div  in  p_DIV_W  clocks per bit; sampled when a frame starts; 0 is treated as 1.
i_dv  in  1  data valid; a word is accepted on an edge where i_dv && o_ready.
i_data  in  p_DATA_BITS  word to send; captured on acceptance.
o_ready  out  1  holding register empty.
o_tx  out  1  serial line, registered, idle high.
o_active  out  1  high for every cycle a frame is on the line (start through last stop bit).
o_done  out  1  one-cycle pulse after the final stop bit of each frame.

Behaviour:
- Reset (async assert, sync release):
  - o_tx = 1, o_ready = 1, o_active = 0, o_done = 0.
  - Holding register empty, shifter state IDLE, counters 0.
  - Reset mid-frame: line goes high immediately; the current frame and any pending word are discarded.
- Holding register:
  - Accept sets it full; o_ready = 0 from the next cycle.
  - i_dv while o_ready = 0 is ignored and data is not captured.
  - The register empties on the edge its word is loaded into the shifter; o_ready returns high after that edge.
  - i_dv on that same edge is not accepted, because o_ready was still low.
- Frame start: on an edge where the shifter is IDLE, or is on the last cycle of its last stop bit, and the holding register is full:
  - load the shift register and latch the divisor (max(i_div, 1));
  - drive o_tx = 0 and o_active = 1.
- Latency:
  - Idle block: accept at edge N, start bit on o_tx from edge N+1.
  - Back-to-back: the next start bit directly follows the last stop bit with zero gap.
- States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE (or -> START if the holding register is full).
  - PARITY is skipped when p_PARITY = 0.
  - Every bit lasts exactly div clocks; the clock counter runs 0..div-1.
  - DATA sends bit index 0..p_DATA_BITS-1.
  - STOP drives 1 for p_STOP_BITS x div clocks.
- Parity bit: XOR of all data bits for even; its inverse for odd.
- Frame length = (1 + p_DATA_BITS + (p_PARITY != 0) + p_STOP_BITS) x div clocks.
- o_done:
  - High for exactly one cycle, the cycle immediately after the last stop-bit cycle.
  - During back-to-back transfer it coincides with the first start-bit cycle of the next frame.
  - o_active drops in that cycle unless a new frame starts.
- o_active is low in IDLE.
- Changing i_div mid-frame has no effect until the next frame start.
- Illegal parameter values stop elaboration through a generate-time check.

Test Plan:
1. 8N1, i_div = 4, send 0xA5 from idle -> o_tx is low for 4 clocks, then 1,0,1,0,0,1,0,1 (4 clocks each), then high for 4; o_active high for 40 clocks; o_done pulses once at clock 41.
2. 8E1, i_div = 2, send 0x07 -> parity bit = 1. 8O1 with the same data -> parity bit = 0. Frame = 22 clocks.
3. 7O2, i_div = 3, two words 0x55 and 0x2A presented back-to-back:
   - the second is accepted while the first transmits and o_ready goes low;
   - the second start bit follows the 6-clock stop period with zero gap;
   - o_done coincides with that start bit.
4. Holding register full, i_dv pulsed with 0xFF -> ignored; the next frame carries the previously accepted word, not 0xFF.
5. Assert i_rst_n low during the 3rd data bit with a word pending -> o_tx = 1 and o_active = 0 immediately; after release o_ready = 1, no frame is sent and no o_done pulse occurs.
6. i_div = 0, 8N1, send 0x01 -> each bit lasts 1 clock, frame = 10 clocks. Changing i_div to 8 mid-frame does not alter the current frame.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: configurable data width, parity and stop bits,
// a run-time baud divisor, and a one-word holding register for gapless back-to-back frames.
module uart_tx_cfg #(
  parameter int p_DATA_BITS = 8,
  parameter int p_PARITY    = 0,
  parameter int p_STOP_BITS = 1,
  parameter int p_DIV_W     = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [p_DIV_W-1:0]     i_div,
  input  logic                   i_dv,
  input  logic [p_DATA_BITS-1:0] i_data,
  output logic                   o_ready,
  output logic                   o_tx,
  output logic                   o_active,
  output logic                   o_done
);

  if (p_DATA_BITS < 5 || p_DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: p_DATA_BITS must be 5..9");
  end
  if (p_PARITY < 0 || p_PARITY > 2) begin : g_bad_parity
    $error("uart_tx_cfg: p_PARITY must be 0, 1 or 2");
  end
  if (p_STOP_BITS < 1 || p_STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: p_STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam int                CNT_W      = 4;
  localparam logic [CNT_W-1:0]  LAST_DATA  = CNT_W'(p_DATA_BITS - 1);
  localparam logic [CNT_W-1:0]  LAST_STOP  = CNT_W'(p_STOP_BITS - 1);
  localparam logic              HAS_PARITY = (p_PARITY != 0);
  localparam logic              ODD_PARITY = (p_PARITY == 2);

  state_t                   state_q,     state_d;
  logic [p_DIV_W-1:0]       clk_cnt_q,   clk_cnt_d;
  logic [p_DIV_W-1:0]       div_q,       div_d;
  logic [CNT_W-1:0]         bit_cnt_q,   bit_cnt_d;
  logic [p_DATA_BITS-1:0]   shreg_q,     shreg_d;
  logic                     par_q,       par_d;
  logic                     tx_q,        tx_d;
  logic                     done_q,      done_d;
  logic                     hold_full_q, hold_full_d;
  logic [p_DATA_BITS-1:0]   hold_data_q, hold_data_d;

  logic bit_end;
  logic last_stop;
  logic load;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    div_d       = div_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    tx_d        = tx_q;
    done_d      = 1'b0;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;

    bit_end   = (clk_cnt_q == div_q - p_DIV_W'(1));
    last_stop = (state_q == S_STOP) && bit_end && (bit_cnt_q == LAST_STOP);
    load      = hold_full_q && ((state_q == S_IDLE) || last_stop);

    if (state_q != S_IDLE) begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + p_DIV_W'(1);
    end

    if (bit_end) begin
      unique case (state_q)
        S_START: begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
          tx_d      = shreg_q[0];
        end
        S_DATA: begin
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            if (HAS_PARITY) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            shreg_d   = shreg_q >> 1;
            tx_d      = shreg_q[1];
          end
        end
        S_PARITY: begin
          state_d   = S_STOP;
          bit_cnt_d = '0;
          tx_d      = 1'b1;
        end
        S_STOP: begin
          if (bit_cnt_q == LAST_STOP) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end

    // A pending word overrides the return to idle so the next start bit follows with no gap.
    if (load) begin
      state_d     = S_START;
      clk_cnt_d   = '0;
      bit_cnt_d   = '0;
      div_d       = (i_div == '0) ? p_DIV_W'(1) : i_div;
      shreg_d     = hold_data_q;
      par_d       = (^hold_data_q) ^ ODD_PARITY;
      tx_d        = 1'b0;
      hold_full_d = 1'b0;
    end

    if (i_dv && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_data_d = i_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      clk_cnt_q   <= '0;
      div_q       <= p_DIV_W'(1);
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      div_q       <= div_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
    end
  end

  assign o_ready  = !hold_full_q;
  assign o_tx     = tx_q;
  assign o_active = (state_q != S_IDLE);
  assign o_done   = done_q;

endmodule
